connect_mode_ctrl: RTL and testbench

- Controls the CONNECT path-select between the compressed path (AIDC) and the bypass path (XHB).
- Sits between the APB enable source and CONNECT's ENABLE_i input.
- Counts outstanding AXI read and write transactions issued by the CNN engine.
- On a mode-change request, blocks new AR/AW, waits for all in-flight traffic to finish, then flips the select, so no burst ever straddles a path switch.

---
 rtl/connect_mode_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_connect_mode_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/connect_mode_ctrl.sv
// -----------------------------------------------------------------------------
// connect_mode_ctrl
//
// Purpose:
//   Owns the CONNECT path select (AIDC compressed path vs. XHB bypass path).
//   The requested mode comes from the APB enable source. The registered select
//   drives CONNECT's ENABLE_i. A change of mode is never applied while AXI
//   traffic from the CNN engine is in flight. The sequence is:
//     1. new AR/AW address handshakes are blocked,
//     2. outstanding reads (AR .. R last), writes (AW .. B) and any partially
//        sent W burst are allowed to finish,
//     3. the select is flipped.
//   This guarantees that no burst ever straddles a path switch.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable_req_i        requested mode (1 = AIDC, 0 = bypass)
//   arvalid_i/arready_i AR handshake from engine / downstream path
//   arvalid_o/arready_o gated AR handshake towards CONNECT / engine
//   rvalid_i/rready_i/rlast_i   R channel, observed only
//   awvalid_i/awready_i AW handshake from engine / downstream path
//   awvalid_o/awready_o gated AW handshake towards CONNECT / engine
//   wvalid_i/wready_i/wlast_i   W channel, observed only
//   bvalid_i/bready_i   B channel, observed only
//   enable_o            registered path select
//   busy_o              high while a mode change is draining or switching
//   switch_done_o       one-cycle pulse in the cycle enable_o changes
//   err_o               sticky: a response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module connect_mode_ctrl #(
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned MAX_OUTST = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_req_i,
  input  logic arvalid_i,
  input  logic arready_i,
  output logic arvalid_o,
  output logic arready_o,
  input  logic rvalid_i,
  input  logic rready_i,
  input  logic rlast_i,
  input  logic awvalid_i,
  input  logic awready_i,
  output logic awvalid_o,
  output logic awready_o,
  input  logic wvalid_i,
  input  logic wready_i,
  input  logic wlast_i,
  input  logic bvalid_i,
  input  logic bready_i,
  output logic enable_o,
  output logic busy_o,
  output logic switch_done_o,
  output logic err_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // Direction index used by all per-direction vectors: 0 = read, 1 = write.
  localparam int DIR_RD = 0;
  localparam int DIR_WR = 1;

  state_e state_q, state_d;
  logic   enable_q, enable_d;
  logic   switch_done_q, switch_done_d;
  logic   err_q, err_d;
  logic   w_busy_q, w_busy_d;

  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] addr_vld;   // raw address valid from the engine
  logic [1:0] addr_rdy;   // raw address ready from downstream
  logic [1:0] gate_vld;   // gated address valid
  logic [1:0] gate_rdy;   // gated address ready
  logic [1:0] addr_blk;   // address channel blocked
  logic [1:0] addr_hs;    // address handshake accepted (count up)
  logic [1:0] resp_done;  // transaction completed (count down)
  logic [1:0] uflow;      // completion seen with nothing outstanding

  logic w_hs;
  logic idle;
  logic not_run;

  assign not_run = (state_q != ST_RUN);

  // ---------------------------------------------------------------------------
  // Channel bundling
  // ---------------------------------------------------------------------------
  assign addr_vld[DIR_RD]  = arvalid_i;
  assign addr_vld[DIR_WR]  = awvalid_i;
  assign addr_rdy[DIR_RD]  = arready_i;
  assign addr_rdy[DIR_WR]  = awready_i;
  // A read is complete on the last R beat; a write is complete on its B.
  assign resp_done[DIR_RD] = rvalid_i & rready_i & rlast_i;
  assign resp_done[DIR_WR] = bvalid_i & bready_i;

  assign arvalid_o = gate_vld[DIR_RD];
  assign arready_o = gate_rdy[DIR_RD];
  assign awvalid_o = gate_vld[DIR_WR];
  assign awready_o = gate_rdy[DIR_WR];

  // ---------------------------------------------------------------------------
  // Per-direction gating and outstanding-transaction counter
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_dir
    logic [CNT_W-1:0] cnt_nxt;
    logic             uflow_nxt;

    // Both halves of the handshake are masked so neither side can see a
    // completed transfer while the channel is closed.
    assign addr_blk[gi] = not_run | (cnt_q[gi] == CNT_MAX);
    assign gate_vld[gi] = addr_vld[gi] & ~addr_blk[gi];
    assign gate_rdy[gi] = addr_rdy[gi] & ~addr_blk[gi];
    assign addr_hs[gi]  = gate_vld[gi] & gate_rdy[gi];

    always_comb begin
      cnt_nxt   = cnt_q[gi];
      uflow_nxt = 1'b0;
      unique case ({addr_hs[gi], resp_done[gi]})
        2'b10: cnt_nxt = cnt_q[gi] + CNT_ONE;
        2'b01: begin
          // A completion with nothing outstanding is a protocol fault;
          // hold at zero instead of wrapping so drain logic stays sane.
          if (cnt_q[gi] == CNT_ZERO) begin
            uflow_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_q[gi] - CNT_ONE;
          end
        end
        default: cnt_nxt = cnt_q[gi];
      endcase
    end

    assign cnt_d[gi] = cnt_nxt;
    assign uflow[gi] = uflow_nxt;
  end

  // ---------------------------------------------------------------------------
  // W burst tracking: a W burst may start before its AW, so an open W burst
  // has to hold off the switch on its own.
  // ---------------------------------------------------------------------------
  assign w_hs = wvalid_i & wready_i;

  always_comb begin
    w_busy_d = w_busy_q;
    if (w_hs) begin
      w_busy_d = ~wlast_i;
    end
  end

  assign err_d = err_q | (|uflow);

  // Everything here is registered state, so the drain decision never depends
  // on same-cycle handshakes.
  assign idle = (cnt_q[DIR_RD] == CNT_ZERO) & (cnt_q[DIR_WR] == CNT_ZERO) & ~w_busy_q;

  // ---------------------------------------------------------------------------
  // Mode-change FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    enable_d      = enable_q;
    switch_done_d = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (enable_req_i != enable_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (enable_req_i == enable_q) begin
          // Request withdrawn: reopen the channels without touching the select.
          state_d = ST_RUN;
        end else if (idle) begin
          state_d = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        // The request is sampled again here; if it moved back the select keeps
        // its value and no pulse is produced.
        enable_d      = enable_req_i;
        switch_done_d = (enable_req_i != enable_q);
        state_d       = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      enable_q      <= 1'b0;
      switch_done_q <= 1'b0;
      err_q         <= 1'b0;
      w_busy_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      switch_done_q <= switch_done_d;
      err_q         <= err_d;
      w_busy_q      <= w_busy_d;
      cnt_q         <= cnt_d;
    end
  end

  assign enable_o      = enable_q;
  assign busy_o        = not_run;
  assign switch_done_o = switch_done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_connect_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_connect_mode_ctrl
//
// Directed bench for connect_mode_ctrl. A transaction-level model tracks
// outstanding reads/writes as plain integers and derives every DUT output
// from them each cycle. Hand-computed literals pin the key timing points.
// -----------------------------------------------------------------------------
module tb_connect_mode_ctrl;

  localparam int MAXO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic req = 1'b0;
  logic arv = 1'b0, arr = 1'b0, rv = 1'b0, rr = 1'b0, rl = 1'b0;
  logic awv = 1'b0, awr = 1'b0, wv = 1'b0, wrd = 1'b0, wl = 1'b0;
  logic bv = 1'b0, br = 1'b0;

  logic arvalid_o, arready_o, awvalid_o, awready_o;
  logic enable_o, busy_o, switch_done_o, err_o;

  int n_tests = 0;
  int n_fail  = 0;

  connect_mode_ctrl #(.CNT_W(4), .MAX_OUTST(MAXO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_req_i (req),
    .arvalid_i    (arv),
    .arready_i    (arr),
    .arvalid_o    (arvalid_o),
    .arready_o    (arready_o),
    .rvalid_i     (rv),
    .rready_i     (rr),
    .rlast_i      (rl),
    .awvalid_i    (awv),
    .awready_i    (awr),
    .awvalid_o    (awvalid_o),
    .awready_o    (awready_o),
    .wvalid_i     (wv),
    .wready_i     (wrd),
    .wlast_i      (wl),
    .bvalid_i     (bv),
    .bready_i     (br),
    .enable_o     (enable_o),
    .busy_o       (busy_o),
    .switch_done_o(switch_done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Transaction-level model
  // ---------------------------------------------------------------------------
  typedef struct {
    int rd;       // reads issued and not yet finished
    int wr;       // writes issued and not yet answered
    bit wopen;    // a W burst is part-way through
    bit en;       // current select
    bit drain;    // waiting for traffic to finish before switching
    bit flip;     // select changes at the next edge
    bit done;     // select changed at the last edge
    bit err;      // a response arrived with nothing outstanding
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.rd = 0; r.wr = 0; r.wopen = 0; r.en = 0;
    r.drain = 0; r.flip = 0; r.done = 0; r.err = 0;
    return r;
  endfunction

  function automatic bit closed(model_t s);
    return s.drain || s.flip;
  endfunction

  function automatic model_t model_step(model_t s);
    model_t n = s;
    int ar_acc, aw_acc, r_fin, b_fin;
    bit quiet;
    ar_acc = (arv && arr && !closed(s) && s.rd < MAXO) ? 1 : 0;
    aw_acc = (awv && awr && !closed(s) && s.wr < MAXO) ? 1 : 0;
    r_fin  = (rv && rr && rl) ? 1 : 0;
    b_fin  = (bv && br) ? 1 : 0;
    n.rd = s.rd + ar_acc - r_fin;
    if (n.rd < 0) begin n.rd = 0; n.err = 1; end
    n.wr = s.wr + aw_acc - b_fin;
    if (n.wr < 0) begin n.wr = 0; n.err = 1; end
    if (wv && wrd) n.wopen = !wl;
    quiet = (s.rd == 0) && (s.wr == 0) && !s.wopen;
    n.done = 0;
    if (s.flip) begin
      n.en = req; n.done = (req != s.en); n.flip = 0; n.drain = 0;
    end else if (s.drain) begin
      if (req == s.en) n.drain = 0;
      else if (quiet) begin n.drain = 0; n.flip = 1; end
    end else if (req != s.en) begin
      n.drain = 1;
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("arvalid_o", arvalid_o, arv && !closed(m) && m.rd < MAXO);
    chk("arready_o", arready_o, arr && !closed(m) && m.rd < MAXO);
    chk("awvalid_o", awvalid_o, awv && !closed(m) && m.wr < MAXO);
    chk("awready_o", awready_o, awr && !closed(m) && m.wr < MAXO);
    chk("enable_o", enable_o, m.en);
    chk("busy_o", busy_o, closed(m));
    chk("switch_done_o", switch_done_o, m.done);
    chk("err_o", err_o, m.err);
  endtask

  // One clock: compare mid-cycle, advance the model on the edge, then leave
  // the caller 1 time unit after the edge to change inputs.
  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      compare();
      @(posedge clk);
      if (!rst_n) m = model_reset();
      else        m = model_step(m);
      #1;
    end
  endtask

  task automatic clr();
    arv = 0; arr = 0; rv = 0; rr = 0; rl = 0;
    awv = 0; awr = 0; wv = 0; wrd = 0; wl = 0; bv = 0; br = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    m = model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("reset enable_o", enable_o, 1'b0);
    chk("reset busy_o", busy_o, 1'b0);
    chk("reset switch_done_o", switch_done_o, 1'b0);
    chk("reset err_o", err_o, 1'b0);
    cycle(2);
    rst_n = 1'b1;
    $display("[TB] reset released");

    // Idle switch: request at cycle N, select changes at N+3.
    cycle(8);
    req = 1;
    cycle();
    chk("idle N+1 busy_o", busy_o, 1'b1);
    cycle();
    chk("idle N+2 busy_o", busy_o, 1'b1);
    chk("idle N+2 enable_o", enable_o, 1'b0);
    cycle();
    chk("idle N+3 enable_o", enable_o, 1'b1);
    chk("idle N+3 switch_done_o", switch_done_o, 1'b1);
    chk("idle N+3 busy_o", busy_o, 1'b0);
    cycle();
    chk("idle N+4 switch_done_o", switch_done_o, 1'b0);
    $display("[TB] idle switch 0->1 done");

    // Drain with traffic: 3 reads and 2 writes outstanding.
    arv = 1; arr = 1; cycle(3); clr();
    awv = 1; awr = 1; cycle(2); clr();
    req = 0;
    cycle();
    arv = 1; arr = 1; awv = 1; awr = 1;
    chk("drain arvalid_o", arvalid_o, 1'b0);
    chk("drain arready_o", arready_o, 1'b0);
    chk("drain awvalid_o", awvalid_o, 1'b0);
    cycle(2);
    rv = 1; rr = 1; rl = 1; cycle(3); rv = 0; rr = 0; rl = 0;
    bv = 1; br = 1; cycle(2); bv = 0; br = 0;
    chk("drain after last B enable_o", enable_o, 1'b1);
    chk("drain after last B busy_o", busy_o, 1'b1);
    cycle();
    chk("drain +1 enable_o", enable_o, 1'b1);
    cycle();
    chk("drain +2 enable_o", enable_o, 1'b0);
    chk("drain +2 switch_done_o", switch_done_o, 1'b1);
    clr();
    cycle(2);
    $display("[TB] drain with 3 reads / 2 writes done");

    // Request withdrawn mid-drain with one read outstanding.
    arv = 1; arr = 1; cycle(); clr();
    req = 1;
    cycle();
    chk("withdraw busy_o", busy_o, 1'b1);
    cycle();
    req = 0;
    cycle();
    chk("withdraw busy_o back", busy_o, 1'b0);
    chk("withdraw enable_o", enable_o, 1'b0);
    chk("withdraw switch_done_o", switch_done_o, 1'b0);
    cycle(3);
    rv = 1; rr = 1; rl = 1; cycle(); clr();
    cycle();
    $display("[TB] withdrawn request done");

    // Partial W burst holds off the switch until its last beat.
    wv = 1; wrd = 1; wl = 0; cycle(); clr();
    req = 1;
    cycle(4);
    chk("wburst hold busy_o", busy_o, 1'b1);
    chk("wburst hold enable_o", enable_o, 1'b0);
    wv = 1; wrd = 1; wl = 1; cycle(); clr();
    cycle(2);
    chk("wburst enable_o", enable_o, 1'b1);
    chk("wburst switch_done_o", switch_done_o, 1'b1);
    cycle();
    $display("[TB] partial W burst done");

    // Saturation: 14 reads, simultaneous issue + finish, then a 15th.
    arv = 1; arr = 1; cycle(14);
    rv = 1; rr = 1; rl = 1; cycle();
    rv = 0; rr = 0; rl = 0; cycle();
    chk("sat arvalid_o", arvalid_o, 1'b0);
    chk("sat arready_o", arready_o, 1'b0);
    chk("sat awvalid_o open", awvalid_o, 1'b0);
    cycle(2);
    rv = 1; rr = 1; rl = 1; cycle();
    rv = 0; rr = 0; rl = 0;
    chk("sat reopened arvalid_o", arvalid_o, 1'b1);
    cycle();
    arv = 0; arr = 0;
    rv = 1; rr = 1; rl = 1; cycle(15); clr();
    cycle(2);
    $display("[TB] saturation done");

    // Underflow on the write counter.
    bv = 1; br = 1; cycle(); clr();
    chk("underflow err_o", err_o, 1'b1);
    req = 0;
    cycle(4);
    chk("underflow switch enable_o", enable_o, 1'b0);
    cycle(2);
    $display("[TB] underflow done");

    // Reset during drain.
    req = 1;
    arv = 1; arr = 1; cycle(); clr();
    cycle(2);
    chk("pre-reset busy_o", busy_o, 1'b1);
    @(negedge clk);
    rst_n = 0;
    #1;
    m = model_reset();
    chk("mid-reset busy_o", busy_o, 1'b0);
    chk("mid-reset enable_o", enable_o, 1'b0);
    chk("mid-reset err_o", err_o, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1;
    req = 0;
    cycle(3);
    $display("[TB] reset mid-drain done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
